// File: rtl/vram_pkg.sv
// vram_pkg: types and widths shared by the VRAM write path.
//   VRAM_ADDR_W / VRAM_DATA_W : native VRAM write-port widths.
//   vram_wr_t                 : one buffered byte write {addr, data}.
package vram_pkg;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 8;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } vram_wr_t;

endpackage

// File: rtl/sync_fifo_m.sv
// sync_fifo_m: single-clock FIFO with registered occupancy state.
//   clk        in   clock
//   rst        in   synchronous reset, active-low (clears pointers only)
//   push       in   write request; ignored while full
//   push_data  in   element to write
//   pop        in   read request; ignored while empty
//   head_data  out  element at the read pointer
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   level      out  occupancy, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module sync_fifo_m #(
  parameter int  DEPTH  = 16,
  parameter type elem_t = vram_pkg::vram_wr_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  elem_t                  push_data,
  input  logic                   pop,
  output elem_t                  head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Storage is intentionally not reset; only the pointers define validity.
  elem_t mem_q [DEPTH];

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    level    = wr_ptr_q - rd_ptr_q;
    // Full refuses a push even when a pop happens in the same cycle.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vram_writer.sv
// vram_writer: CPU-side write buffer in front of the VRAM write port.
//   clk        in   pixel clock
//   rst        in   synchronous reset, active-low
//   req_valid  in   CPU write request present
//   req_ready  out  buffer can accept (not full), from registered state only
//   req_addr   in   VRAM byte address
//   req_data   in   byte to write
//   writable   in   window in which VRAM may be written
//   vram_we    out  registered write strobe, one cycle per byte
//   vram_addr  out  registered write address (holds when idle)
//   vram_data  out  registered write data (holds when idle)
//   level      out  buffer occupancy
//   busy       out  entries buffered or a write in flight
// A byte leaves the buffer only at an edge where writable is sampled high,
// so the write lands in the cycle after that sample; the timing generator
// closes its window one clock early to absorb this.
module vram_writer
  import vram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  input  logic                   writable,
  output logic                   vram_we,
  output logic [ADDR_W-1:0]      vram_addr,
  output logic [DATA_W-1:0]      vram_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  vram_wr_t push_entry;
  vram_wr_t head_entry;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;

  logic              vram_we_q,   vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_data_q, vram_data_d;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = VRAM_ADDR_W'(req_addr);
    push_entry.data = VRAM_DATA_W'(req_data);
  end

  sync_fifo_m #(
    .DEPTH  (DEPTH),
    .elem_t (vram_wr_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // No bypass: a byte accepted this edge is at the head next cycle at the
  // earliest, so pop only looks at registered FIFO state.
  always_comb begin
    pop         = writable && !fifo_empty;
    vram_we_d   = pop;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    if (pop) begin
      vram_addr_d = ADDR_W'(head_entry.addr);
      vram_data_d = DATA_W'(head_entry.data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign req_ready = !fifo_full;
  assign vram_we   = vram_we_q;
  assign vram_addr = vram_addr_q;
  assign vram_data = vram_data_q;
  assign busy      = (level != '0) || vram_we_q;

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: directed and random stimulus against a queue-based model
// of the write buffer (occupancy = queue size, a write retires the oldest
// byte at each edge where writable is high and something is queued).
module tb_vram_writer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [7:0]  req_data;
  logic        writable;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [4:0]  level;
  logic        busy;

  vram_writer #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .writable  (writable),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .level     (level),
    .busy      (busy)
  );

  always #40 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [11:0] m_addr;
  logic [7:0]  m_data;
  logic        m_wsample;
  int          pops;
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, updating the model from the inputs that edge samples.
  task automatic tick();
    int   n;
    bit   acc;
    bit   pp;
    ent_t e;
    n   = mq.size();
    acc = (rst === 1'b1) && req_valid && (n < DEPTH);
    pp  = (rst === 1'b1) && writable && (n > 0);
    if (rst !== 1'b1) begin
      mq.delete();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      m_we = pp;
      if (pp) begin
        e      = mq.pop_front();
        m_addr = e.a;
        m_data = e.d;
        pops++;
      end
      if (acc) begin
        e.a = req_addr;
        e.d = req_data;
        mq.push_back(e);
      end
    end
    m_wsample = writable;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "/we"},    vram_we,   m_we);
    check({tag, "/addr"},  vram_addr, m_addr);
    check({tag, "/data"},  vram_data, m_data);
    check({tag, "/level"}, level,     mq.size());
    check({tag, "/ready"}, req_ready, (mq.size() < DEPTH));
    check({tag, "/busy"},  busy,      (mq.size() != 0) || m_we);
  endtask

  initial begin
    int nw;
    int pv;
    int pw;
    int rpops;
    errors    = 0;
    checks    = 0;
    pops      = 0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_wsample = 1'b0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    writable  = 1'b0;

    // Reset with writable low
    tick();
    tick();
    check("rst_ready", req_ready, 1);
    check("rst_level", level, 0);
    check("rst_we",    vram_we, 0);
    check("rst_busy",  busy, 0);
    check("rst_addr",  vram_addr, 0);
    rst = 1'b1;
    tick();
    check_model("idle");

    // Single push with writable low: buffered, no write
    req_valid = 1'b1; req_addr = 12'h3C0; req_data = 8'h1B;
    tick();
    req_valid = 1'b0;
    check("push1_level", level, 1);
    check("push1_we",    vram_we, 0);
    check("push1_busy",  busy, 1);
    writable = 1'b1;
    tick();
    check("drain1_we",   vram_we, 1);
    check("drain1_addr", vram_addr, 12'h3C0);
    check("drain1_data", vram_data, 8'h1B);
    tick();
    check("drain1_done", vram_we, 0);
    check("drain1_hold", vram_addr, 12'h3C0);

    // Fill latency with writable held high
    req_valid = 1'b1; req_addr = 12'h010; req_data = 8'hAA;
    tick();
    req_valid = 1'b0;
    check("lat_n_we",    vram_we, 0);
    check("lat_n_level", level, 1);
    tick();
    check("lat_n1_we",   vram_we, 1);
    check("lat_n1_addr", vram_addr, 12'h010);
    check("lat_n1_data", vram_data, 8'hAA);
    tick();
    check("lat_n2_we",   vram_we, 0);
    check_model("lat");

    // Fill to full, hold a 17th request, then drain
    writable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1'b1;
      req_addr  = 12'(i);
      req_data  = 8'(i) ^ 8'hFF;
      tick();
    end
    check("full_level", level, 16);
    check("full_ready", req_ready, 0);
    req_addr = 12'h123; req_data = 8'h45;
    tick();
    tick();
    check("held_level", level, 16);
    check_model("held");
    writable = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      if (k == 1) req_valid = 1'b0;
      check("drain_we",   vram_we, 1);
      check("drain_addr", vram_addr, (k < DEPTH) ? 32'(k) : 32'h123);
      check("drain_data", vram_data, (k < DEPTH) ? 32'(8'(k) ^ 8'hFF) : 32'h45);
      if (k == 0) check("ready_after_pop", req_ready, 1);
      check_model("drain");
    end
    writable = 1'b0;
    tick();
    check("drain_end_we", vram_we, 0);
    check("drain_end_level", level, 0);

    // Toggle writable 1,0,1,0 with 4 entries queued
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 12'h200 + 12'(i);
      req_data  = 8'h50 + 8'(i);
      tick();
    end
    req_valid = 1'b0;
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      writable = (i % 2 == 0);
      tick();
      if (vram_we) nw++;
      check_model("toggle");
    end
    writable = 1'b0;
    tick();
    if (vram_we) nw++;
    check("toggle_writes", nw, 2);
    check("toggle_level", level, 2);
    check("toggle_last_addr", vram_addr, 12'h201);
    writable = 1'b1;
    tick();
    tick();
    writable = 1'b0;
    tick();
    check_model("toggle_drain");

    // Reset mid-drain with 8 entries queued
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = 12'h7F0 + 12'(i);
      req_data  = 8'(i * 3);
      tick();
    end
    req_valid = 1'b0;
    writable  = 1'b1;
    tick();
    tick();
    check("middrain_we", vram_we, 1);
    rst = 1'b0;
    tick();
    check("mrst_we",    vram_we, 0);
    check("mrst_level", level, 0);
    check("mrst_ready", req_ready, 1);
    check("mrst_busy",  busy, 0);
    check("mrst_addr",  vram_addr, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_we", vram_we, 0);
    end

    // Random push / writable traffic
    rpops = pops;
    pv = 50;
    pw = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) begin
        pv = $urandom_range(15, 95);
        pw = $urandom_range(10, 95);
      end
      req_valid = ($urandom_range(0, 99) < pv);
      req_addr  = 12'($urandom);
      req_data  = 8'($urandom);
      writable  = ($urandom_range(0, 99) < pw);
      tick();
      check_model("rnd");
      check("rnd_we_needs_writable", vram_we && !m_wsample, 0);
    end
    rpops = pops - rpops;
    check("rnd_ptr_wraps", (rpops / (2 * DEPTH)) > 10, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
